lcd_bus_receiver: RTL and testbench

//   HD44780-compatible receiving end of the 2x16 character-LCD write bus (lcd_regsel/lcd_read/lcd_enable/lcd_data).

---
 rtl/lcd_bus_receiver.sv | 218 +++++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver
//   Receiving end of an HD44780-style character-LCD write bus. Decodes command and
//   data strobes into a shadow DDRAM and presents the visible 2x16 window as two
//   128-bit lines (char i at [127-8i -: 8]). Also models the busy flag and flags
//   writes that arrive while the controller would still be busy.
//   Optional nibble-transfer support is enabled by defining LCD_RX_4BIT_EN.
module lcd_bus_receiver #(
    parameter int BUSY_CYCLES  = 1850,
    parameter int CLEAR_CYCLES = 76000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         lcd_regsel,
    input  logic         lcd_read,
    input  logic         lcd_enable,
    input  logic [7:0]   lcd_data,
    output logic [127:0] topline,
    output logic [127:0] bottomline,
    output logic         busy,
    output logic         updated,
    output logic         proto_err,
    output logic         display_on
);

    localparam int MAXC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] LD_BUSY  = CW'(BUSY_CYCLES);
    localparam logic [CW-1:0] LD_CLEAR = CW'(CLEAR_CYCLES);

    // Registered bus sample; the strobe is detected against the live E input
    logic         r_e;
    logic         r_rs;
    logic         r_rw;
    logic [7:0]   r_d;

    logic         w_strobe;
    logic         w_wr;
    logic         w_exec;
    logic [7:0]   w_byte;
    logic         w_busy;

    logic [127:0] r_top;
    logic [127:0] r_bot;
    logic [6:0]   r_addr;
    logic         r_incr;
    logic         r_cg;
    logic         r_upd;
    logic         r_perr;
    logic         r_disp;
    logic [CW-1:0] r_cnt;

    // Cursor step forward: the two 40-char DDRAM lines form one 80-char ring.
    // Addresses outside both lines just wrap as plain 7-bit values.
    function automatic logic [6:0] step_up(input logic [6:0] a);
        if (a == 7'h27)
            return 7'h40;
        else if (a == 7'h67)
            return 7'h00;
        else
            return a + 7'd1;
    endfunction

    // Cursor step backward, mirror image of step_up
    function automatic logic [6:0] step_dn(input logic [6:0] a);
        if (a == 7'h00)
            return 7'h67;
        else if (a == 7'h40)
            return 7'h27;
        else
            return a - 7'd1;
    endfunction

    assign w_strobe = r_e & ~lcd_enable;
    assign w_wr     = w_strobe & ~r_rw;
    assign w_busy   = (r_cnt != '0);

    // Sample the bus every cycle; reset drops any half-seen strobe
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_e  <= 1'b0;
            r_rs <= 1'b0;
            r_rw <= 1'b0;
            r_d  <= 8'h00;
        end else begin
            r_e  <= lcd_enable;
            r_rs <= lcd_regsel;
            r_rw <= lcd_read;
            r_d  <= lcd_data;
        end
    end

`ifdef LCD_RX_4BIT_EN
    // Nibble mode: r_nib_hi=1 means the next strobe carries the high nibble.
    // The interface width (DL) is the only function-set field with an effect here;
    // N is irrelevant for a fixed two-line mirror and is not stored.
    logic       r_nib_mode;
    logic       r_nib_hi;
    logic [3:0] r_nib_buf;

    // Collect the high nibble; any completed function set updates the bus width
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_nib_mode <= 1'b0;
            r_nib_hi   <= 1'b1;
            r_nib_buf  <= 4'h0;
        end else if (w_wr) begin
            if (r_nib_mode && r_nib_hi) begin
                r_nib_buf <= r_d[7:4];
                r_nib_hi  <= 1'b0;
            end else begin
                r_nib_hi <= 1'b1;
                if (!r_rs && (w_byte[7:5] == 3'b001))
                    r_nib_mode <= ~w_byte[4];
            end
        end
    end

    // Only a full byte (8-bit strobe or completing low nibble) is executed
    always_comb begin
        w_byte = r_nib_mode ? {r_nib_buf, r_d[7:4]} : r_d;
        w_exec = w_wr && !(r_nib_mode && r_nib_hi);
    end
`else
    // 8-bit bus only: every write strobe carries a complete byte
    always_comb begin
        w_byte = r_d;
        w_exec = w_wr;
    end
`endif

    // Execute commands/data, run the busy counter and track protocol errors
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_top  <= {16{8'h20}};
            r_bot  <= {16{8'h20}};
            r_addr <= 7'h00;
            r_incr <= 1'b1;
            r_cg   <= 1'b0;
            r_upd  <= 1'b0;
            r_perr <= 1'b0;
            r_disp <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_upd <= 1'b0;
            if (w_busy)
                r_cnt <= r_cnt - 1'b1;
            // A write during busy is flagged but still carried out below
            if (w_wr && w_busy)
                r_perr <= 1'b1;
            if (w_exec) begin
                if (r_rs) begin
                    r_cnt <= LD_BUSY;
                    // CGRAM writes have no visible effect and leave the DDRAM cursor alone
                    if (!r_cg) begin
                        if (r_addr[6:4] == 3'b000) begin
                            r_top[8*(15-int'(r_addr[3:0])) +: 8] <= w_byte;
                            r_upd <= 1'b1;
                        end else if (r_addr[6:4] == 3'b100) begin
                            r_bot[8*(15-int'(r_addr[3:0])) +: 8] <= w_byte;
                            r_upd <= 1'b1;
                        end
                        r_addr <= r_incr ? step_up(r_addr) : step_dn(r_addr);
                    end
                end else begin
                    casez (w_byte)
                        8'b1???????: begin
                            r_addr <= w_byte[6:0];
                            r_cg   <= 1'b0;
                            r_cnt  <= LD_BUSY;
                        end
                        8'b01??????: begin
                            r_cg  <= 1'b1;
                            r_cnt <= LD_BUSY;
                        end
                        8'b001?????: begin
                            r_cnt <= LD_BUSY;
                        end
                        8'b0001????: begin
                            // Display shift (S/C=1) does not move the window in this model
                            if (!w_byte[3])
                                r_addr <= w_byte[2] ? step_up(r_addr) : step_dn(r_addr);
                            r_cnt <= LD_BUSY;
                        end
                        8'b00001???: begin
                            r_disp <= w_byte[2];
                            r_cnt  <= LD_BUSY;
                        end
                        8'b000001??: begin
                            r_incr <= w_byte[1];
                            r_cnt  <= LD_BUSY;
                        end
                        8'b0000001?: begin
                            r_addr <= 7'h00;
                            r_cnt  <= LD_CLEAR;
                        end
                        8'b00000001: begin
                            r_top  <= {16{8'h20}};
                            r_bot  <= {16{8'h20}};
                            r_addr <= 7'h00;
                            r_incr <= 1'b1;
                            r_upd  <= 1'b1;
                            r_cnt  <= LD_CLEAR;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign topline    = r_top;
    assign bottomline = r_bot;
    assign busy       = w_busy;
    assign updated    = r_upd;
    assign proto_err  = r_perr;
    assign display_on = r_disp;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver
//   Scoreboard bench: each stimulus strobe is applied to a DDRAM model (flat
//   128-byte array, cursor stepping done on an 80-char ring); every expected
//   visible change is queued as a {topline,bottomline} snapshot and a monitor
//   pops one per updated pulse. Covers nibble transfers when LCD_RX_4BIT_EN is defined.
module tb_lcd_bus_receiver;

    localparam int BUSY = 20;
    localparam int CLR  = 60;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         lcd_regsel = 1'b0;
    logic         lcd_read = 1'b0;
    logic         lcd_enable = 1'b0;
    logic [7:0]   lcd_data = 8'h00;
    logic [127:0] topline;
    logic [127:0] bottomline;
    logic         busy;
    logic         updated;
    logic         proto_err;
    logic         display_on;

    always #5 clk = ~clk;

    lcd_bus_receiver #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLR)) dut (
        .clk(clk), .reset(reset), .lcd_regsel(lcd_regsel), .lcd_read(lcd_read),
        .lcd_enable(lcd_enable), .lcd_data(lcd_data), .topline(topline),
        .bottomline(bottomline), .busy(busy), .updated(updated),
        .proto_err(proto_err), .display_on(display_on)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_upd = 0;
    int cyc = 0;
    logic [255:0] exp_q[$];

    // Reference model state
    logic [7:0] m_ram [128];
    int         m_addr;
    bit         m_incr, m_cg, m_disp, m_perr, m_nib, m_hi;
    logic [3:0] m_buf;
    int         last_t, last_ld;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] snap();
        logic [255:0] s;
        for (int i = 0; i < 16; i++) begin
            s[255-8*i -: 8] = m_ram[i];
            s[127-8*i -: 8] = m_ram[64+i];
        end
        return s;
    endfunction

    // Lines 0x00-0x27 and 0x40-0x67 are one 80-position ring; others wrap mod 128
    function automatic int m_step(input int a, input bit up);
        int p;
        if (a <= 'h27 || (a >= 'h40 && a <= 'h67)) begin
            p = (a < 'h40) ? a : a - 'h40 + 40;
            p = (p + (up ? 1 : 79)) % 80;
            return (p < 40) ? p : p - 40 + 'h40;
        end
        return (a + (up ? 1 : 127)) % 128;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 128; i++) m_ram[i] = 8'h20;
        m_addr = 0; m_incr = 1; m_cg = 0; m_disp = 0; m_perr = 0;
        m_nib = 0; m_hi = 1; m_buf = 4'h0; last_ld = 0; last_t = 0;
        exp_q.delete();
    endfunction

    // Apply one complete byte; returns the busy time it costs (0 = none)
    function automatic int m_exec(input bit rs, input logic [7:0] b);
        if (rs) begin
            if (!m_cg) begin
                if (m_addr < 16 || (m_addr >= 64 && m_addr < 80)) begin
                    m_ram[m_addr] = b;
                    exp_q.push_back(snap());
                end
                m_addr = m_step(m_addr, m_incr);
            end
            return BUSY;
        end
        if (b[7]) begin m_addr = int'(b[6:0]); m_cg = 0; return BUSY; end
        if (b[6]) begin m_cg = 1; return BUSY; end
        if (b[5]) begin
`ifdef LCD_RX_4BIT_EN
            m_nib = !b[4];
`endif
            return BUSY;
        end
        if (b[4]) begin
            if (!b[3]) m_addr = m_step(m_addr, b[2]);
            return BUSY;
        end
        if (b[3]) begin m_disp = b[2]; return BUSY; end
        if (b[2]) begin m_incr = b[1]; return BUSY; end
        if (b[1]) begin m_addr = 0; return CLR; end
        if (b[0]) begin
            for (int i = 0; i < 128; i++) m_ram[i] = 8'h20;
            m_addr = 0; m_incr = 1;
            exp_q.push_back(snap());
            return CLR;
        end
        return 0;
    endfunction

    // One E pulse; model is updated right after the edge that sees E fall
    task automatic strobe(input bit rs, input bit rw, input logic [7:0] d, input int gap);
        int ld;
        logic [7:0] b;
        @(negedge clk);
        lcd_regsel = rs; lcd_read = rw; lcd_data = d; lcd_enable = 1'b1;
        repeat (2) @(negedge clk);
        lcd_enable = 1'b0;
        @(posedge clk);
        #1;
        if (!rw) begin
            if (last_ld > 0 && (cyc - last_t) <= last_ld) m_perr = 1;
            ld = 0;
            if (m_nib && m_hi) begin
                m_buf = d[7:4];
                m_hi = 0;
            end else begin
                b = m_nib ? {m_buf, d[7:4]} : d;
                m_hi = 1;
                ld = m_exec(rs, b);
            end
            if (ld > 0) begin last_ld = ld; last_t = cyc; end
        end
        repeat (gap) @(negedge clk);
    endtask

    // Well-spaced write that never violates busy
    task automatic wr(input bit rs, input logic [7:0] d);
        strobe(rs, 1'b0, d, (!rs && (d == 8'h01 || d[7:1] == 7'h01)) ? CLR + 3 : BUSY + 3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; lcd_enable = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        m_reset();
    endtask

    task automatic chk_state(input string nm);
        chk({nm, "_lines"}, {topline, bottomline}, snap());
        chk({nm, "_perr"}, 256'(proto_err), 256'(m_perr));
        chk({nm, "_disp"}, 256'(display_on), 256'(m_disp));
    endtask

    // Monitor: every updated pulse must match the oldest queued snapshot
    always @(negedge clk) begin
        if (updated === 1'b1) begin
            n_upd++;
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_updated: got a pulse, expected none");
            end else begin
                chk("updated_snapshot", {topline, bottomline}, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [127:0] msg;
        int           n0, sel;
        logic [7:0]   c;

        m_reset();
        // T1: reset then idle
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("t1_top", 256'(topline), 256'({16{8'h20}}));
        chk("t1_bottom", 256'(bottomline), 256'({16{8'h20}}));
        chk("t1_busy", 256'(busy), 256'(0));
        chk("t1_perr", 256'(proto_err), 256'(0));
        chk("t1_disp", 256'(display_on), 256'(0));

        // T2: clear, busy window, then a full top line
        strobe(1'b0, 1'b0, 8'h01, 2);
        chk("t2_busy_after_clear", 256'(busy), 256'(1));
        repeat (CLR + 2) @(negedge clk);
        chk("t2_busy_expired", 256'(busy), 256'(0));
        n0 = n_upd;
        msg = "Welcome to Simon";
        for (int i = 0; i < 16; i++) wr(1'b1, msg[127-8*i -: 8]);
        chk("t2_pulses", 256'(n_upd - n0), 256'(16));
        chk("t2_top", 256'(topline), 256'(msg));
        chk("t2_perr", 256'(proto_err), 256'(0));

        // T3: bottom line, decrement mode and cursor shift left
        wr(1'b0, 8'hC0); wr(1'b1, "P"); wr(1'b1, "r");
        chk("t3_bottom_pr", 256'(bottomline[127:112]), 256'(16'h5072));
        chk("t3_top_kept", 256'(topline), 256'(msg));
        wr(1'b0, 8'h04); wr(1'b0, 8'h10); wr(1'b1, "X"); wr(1'b1, "Y");
        chk("t3_char1_x", 256'(bottomline[119:112]), 256'("X"));
        chk("t3_char0_y", 256'(bottomline[127:120]), 256'("Y"));

        // T4: write at 0x27 is invisible, cursor wraps to 0x40
        wr(1'b0, 8'h06); wr(1'b0, 8'hA7); wr(1'b1, "A"); wr(1'b1, "B");
        chk("t4_wrap_b", 256'(bottomline[127:120]), 256'("B"));
        chk_state("t4");

        // Read strobes change nothing
        strobe(1'b1, 1'b1, "Q", 5);
        strobe(1'b0, 1'b1, 8'h01, 5);
        chk_state("read_ignored");

        // T5: write inside the busy window
        strobe(1'b1, 1'b0, "1", BUSY + 3);
        strobe(1'b1, 1'b0, "2", 10);
        strobe(1'b1, 1'b0, "3", BUSY + 3);
        chk("t5_perr_set", 256'(proto_err), 256'(1));
        chk_state("t5");
        wr(1'b1, "4");
        chk("t5_perr_sticky", 256'(proto_err), 256'(1));
        do_reset();
        repeat (2) @(negedge clk);
        chk("t5_perr_cleared", 256'(proto_err), 256'(0));
        chk_state("t5_reset");

        // Reset during busy and with a strobe in flight
        wr(1'b0, 8'h0C);
        strobe(1'b0, 1'b0, 8'h01, 3);
        @(negedge clk);
        lcd_regsel = 1'b1; lcd_read = 1'b0; lcd_data = "Z"; lcd_enable = 1'b1;
        @(negedge clk);
        reset = 1'b0; lcd_enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_reset();
        repeat (3) @(negedge clk);
        chk("midreset_busy", 256'(busy), 256'(0));
        chk_state("midreset");

        // Randomised traffic against the model
        for (int k = 0; k < 300; k++) begin
            sel = int'($urandom_range(0, 19));
            if (sel < 9) begin
                c = 8'($urandom_range(8'h21, 8'h7E));
                wr(1'b1, c);
            end else if (sel < 12) begin
                if ($urandom_range(0, 3) != 0)
                    c = {1'b1, ($urandom_range(0, 1) != 0) ? 3'b100 : 3'b000, 4'($urandom)};
                else
                    c = {1'b1, 7'($urandom)};
                wr(1'b0, c);
            end else if (sel == 12) wr(1'b0, {6'b000001, 2'($urandom)});
            else if (sel == 13) wr(1'b0, {4'b0001, 4'($urandom)});
            else if (sel == 14) wr(1'b0, {5'b00001, 3'($urandom)});
            else if (sel == 15) wr(1'b0, {7'b0000001, 1'($urandom)});
            else if (sel == 16) wr(1'b0, ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00);
            else if (sel == 17) wr(1'b0, {4'b0011, 4'($urandom)});
            else if (sel == 18) wr(1'b0, ($urandom_range(0, 2) == 0) ? {2'b01, 6'($urandom)} : 8'h80);
            else strobe(1'($urandom), 1'b1, 8'($urandom), 4);
            if (k % 25 == 24) begin
                chk_state("random");
                chk("random_busy_idle", 256'(busy), 256'(0));
            end
        end

`ifdef LCD_RX_4BIT_EN
        // T6: enter nibble mode, then 'A' as two nibbles
        wr(1'b0, 8'h80); wr(1'b0, 8'h06);
        wr(1'b0, 8'h28);
        chk("t6_idle", 256'(busy), 256'(0));
        strobe(1'b1, 1'b0, 8'h40, 3);
        chk("t6_busy_first_nibble", 256'(busy), 256'(0));
        strobe(1'b1, 1'b0, 8'h10, 2);
        chk("t6_busy_second_nibble", 256'(busy), 256'(1));
        repeat (BUSY + 3) @(negedge clk);
        chk("t6_char_a", 256'(topline[127:120]), 256'(8'h41));
        chk_state("t6");
`endif

        repeat (5) @(negedge clk);
        chk("pending_updates", 256'(exp_q.size()), 256'(0));
        chk_state("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
